seq_state_decoder: RTL and testbench

//  Consumer end of the sequencer's 24-line one-hot state bus. Registers and decodes the
//  one-hot state plus the 4-bit instruction class into a binary cycle index and the fetch

---
 rtl/seq_state_decoder_pkg.sv | 48 ++++
 rtl/seq_state_decoder_if.sv | 31 +++
 rtl/seq_state_decoder_checker.sv | 81 ++++++++
 rtl/seq_state_decoder.sv | 112 +++++++++++
 tb/tb_seq_state_decoder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seq_state_decoder_pkg.sv
// Shared definitions for the relay sequencer state decoder: instruction
// classes, one-hot state constants, final-state lookup and error codes.
package relay_seq_pkg;

    localparam int NUM_STATES_C = 24;

    // Instruction class codes as presented by the decode logic.
    typedef enum logic [3:0] {
        CLS_MOV8  = 4'b0000,
        CLS_ALU   = 4'b1000,
        CLS_SETAB = 4'b0100,
        CLS_LDST  = 4'b1001,
        CLS_MOV16 = 4'b1010,
        CLS_INCXY = 4'b1011,
        CLS_GOTO  = 4'b1100
    } inst_class_e;

    // One-hot encodings of the states the decoder and checker care about.
    localparam logic [NUM_STATES_C-1:0] ST_1  = 24'h00_0001;
    localparam logic [NUM_STATES_C-1:0] ST_8  = 24'h00_0080;
    localparam logic [NUM_STATES_C-1:0] ST_12 = 24'h00_0800;
    localparam logic [NUM_STATES_C-1:0] ST_14 = 24'h00_2000;
    localparam logic [NUM_STATES_C-1:0] ST_24 = 24'h80_0000;

    // Sequence checker error causes.
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_ONEHOT = 2'd1;
    localparam logic [1:0] ERR_SUCC   = 2'd2;
    localparam logic [1:0] ERR_CLASS  = 2'd3;

    // Checker FSM states.
    typedef enum logic {
        CHK_UNSYNC = 1'b0,
        CHK_TRACK  = 1'b1
    } chk_state_e;

    // Last sequencer state (1-based) of an instruction of the given class.
    // Unknown codes run the full 24-state walk like goto.
    function automatic logic [4:0] final_state(input logic [3:0] cls);
        case (cls)
            CLS_MOV8, CLS_ALU, CLS_SETAB: final_state = 5'd8;
            CLS_LDST, CLS_MOV16:          final_state = 5'd12;
            CLS_INCXY:                    final_state = 5'd14;
            default:                      final_state = 5'd24;
        endcase
    endfunction

endpackage

// File: rtl/seq_state_decoder_if.sv
// Bus between the sequencer (master) and the state decoder (slave):
// one-hot state plus instruction class in, decoded strobes and status out.
interface seq_state_decoder_if #(
    parameter int NUM_STATES = 24,
    parameter int CNT_W      = 16
);
    logic [NUM_STATES-1:0] state_i;
    logic [3:0]            instruction_bits;
    logic [4:0]            cycle_idx;
    logic                  sel_pc;
    logic                  mem_rd;
    logic                  ld_inst;
    logic                  ld_inc;
    logic                  sel_inc_ld_pc;
    logic                  instr_done;
    logic [CNT_W-1:0]      instr_count;
    logic                  seq_err;
    logic [1:0]            err_code;

    modport master (
        output state_i, instruction_bits,
        input  cycle_idx, sel_pc, mem_rd, ld_inst, ld_inc, sel_inc_ld_pc,
               instr_done, instr_count, seq_err, err_code
    );

    modport slave (
        input  state_i, instruction_bits,
        output cycle_idx, sel_pc, mem_rd, ld_inst, ld_inc, sel_inc_ld_pc,
               instr_done, instr_count, seq_err, err_code
    );
endinterface

// File: rtl/seq_state_decoder_checker.sv
// Sequence protocol checker: locks onto state_1, then predicts each
// successor and records the first violation as a sticky error.
module seq_checker
    import relay_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_onehot,
    input  logic [4:0] i_hot_idx,
    input  logic       i_final_hit,
    input  logic [3:0] i_instr_bits,
    input  logic [3:0] i_class,
    output logic       o_seq_err,
    output logic [1:0] o_err_code
);

    chk_state_e r_state;
    chk_state_e w_state_next;
    logic [4:0] r_prev_idx;
    logic       r_prev_final;
    logic       r_seq_err;
    logic [1:0] r_err_code;
    logic       w_err_hit;
    logic [1:0] w_err_cause;
    logic [4:0] w_pred_idx;

    // Next state and error detection; causes are ranked not-one-hot first.
    always_comb begin
        w_state_next = r_state;
        w_err_hit    = 1'b0;
        w_err_cause  = ERR_NONE;
        w_pred_idx   = r_prev_final ? 5'd1 : (r_prev_idx + 5'd1);
        case (r_state)
            CHK_UNSYNC: begin
                if (i_onehot && (i_hot_idx == 5'd1)) begin
                    w_state_next = CHK_TRACK;
                end
            end
            CHK_TRACK: begin
                if (!i_onehot) begin
                    w_err_hit   = 1'b1;
                    w_err_cause = ERR_ONEHOT;
                end else if (i_hot_idx != w_pred_idx) begin
                    w_err_hit   = 1'b1;
                    w_err_cause = ERR_SUCC;
                end else if (((i_hot_idx == 5'd12) || (i_hot_idx == 5'd14)) &&
                             (i_instr_bits != i_class)) begin
                    w_err_hit   = 1'b1;
                    w_err_cause = ERR_CLASS;
                end
                if (w_err_hit) begin
                    w_state_next = CHK_UNSYNC;
                end
            end
            default: w_state_next = CHK_UNSYNC;
        endcase
    end

    // State register, predecessor history and sticky first-error capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= CHK_UNSYNC;
            r_prev_idx   <= 5'd0;
            r_prev_final <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_state_next;
            r_prev_idx   <= i_hot_idx;
            r_prev_final <= i_final_hit;
            if (w_err_hit && !r_seq_err) begin
                r_seq_err  <= 1'b1;
                r_err_code <= w_err_cause;
            end
        end
    end

    assign o_seq_err  = r_seq_err;
    assign o_err_code = r_err_code;

endmodule

// File: rtl/seq_state_decoder.sv
// Decodes the sequencer's 24-line one-hot state and the instruction class
// into a registered cycle index, fetch strobes, end-of-instruction pulse
// and retired-instruction count. Define SEQ_CHECK_EN to build the
// sequence checker (seq_err / err_code); otherwise both read 0.
// The decode ranges assume NUM_STATES is exactly 24.
module seq_state_decoder
    import relay_seq_pkg::*;
#(
    parameter int NUM_STATES = 24,
    parameter int CNT_W      = 16
) (
    input logic               clock,
    input logic               reset,
    seq_state_decoder_if.slave bus
);

    logic [4:0]       w_hot_cnt;
    logic [4:0]       w_hot_idx;
    logic             w_onehot;
    logic [4:0]       w_idx;
    logic             w_is_s8;
    logic [4:0]       w_final;
    logic             w_done;
    logic             w_seq_err;
    logic [1:0]       w_err_code;

    logic [3:0]       r_class;
    logic [4:0]       r_cycle_idx;
    logic             r_sel_pc;
    logic             r_mem_rd;
    logic             r_ld_inst;
    logic             r_ld_inc;
    logic             r_sel_inc_ld_pc;
    logic             r_done;
    logic [CNT_W-1:0] r_count;

    // Count hot lines and remember the (1-based) index of the hot one.
    always_comb begin
        w_hot_cnt = 5'd0;
        w_hot_idx = 5'd0;
        for (int k = 0; k < NUM_STATES; k++) begin
            if (bus.state_i[k]) begin
                w_hot_cnt = w_hot_cnt + 5'd1;
                w_hot_idx = 5'(k + 1);
            end
        end
    end

    assign w_onehot = (w_hot_cnt == 5'd1);
    assign w_idx    = w_onehot ? w_hot_idx : 5'd0;
    assign w_is_s8  = (bus.state_i == ST_8);

    // At state_8 the class is only being latched now, so decide on the live bits.
    assign w_final  = w_is_s8 ? final_state(bus.instruction_bits) : final_state(r_class);
    assign w_done   = w_onehot && (w_hot_idx == w_final);

    // Registered decode outputs, class latch and retired counter (wraps naturally).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_class         <= 4'd0;
            r_cycle_idx     <= 5'd0;
            r_sel_pc        <= 1'b0;
            r_mem_rd        <= 1'b0;
            r_ld_inst       <= 1'b0;
            r_ld_inc        <= 1'b0;
            r_sel_inc_ld_pc <= 1'b0;
            r_done          <= 1'b0;
            r_count         <= '0;
        end else begin
            if (w_is_s8) begin
                r_class <= bus.instruction_bits;
            end
            r_cycle_idx     <= w_idx;
            r_sel_pc        <= (w_idx >= 5'd1) && (w_idx <= 5'd6);
            r_mem_rd        <= (w_idx >= 5'd2) && (w_idx <= 5'd5);
            r_ld_inst       <= (w_idx >= 5'd3) && (w_idx <= 5'd4);
            r_ld_inc        <= (w_idx >= 5'd2) && (w_idx <= 5'd5);
            r_sel_inc_ld_pc <= (w_idx >= 5'd7) && (w_idx <= 5'd8);
            r_done          <= w_done;
            r_count         <= r_count + CNT_W'(w_done);
        end
    end

`ifdef SEQ_CHECK_EN
    seq_checker u_checker (
        .clock        (clock),
        .reset        (reset),
        .i_onehot     (w_onehot),
        .i_hot_idx    (w_hot_idx),
        .i_final_hit  (w_done),
        .i_instr_bits (bus.instruction_bits),
        .i_class      (r_class),
        .o_seq_err    (w_seq_err),
        .o_err_code   (w_err_code)
    );
`else
    assign w_seq_err  = 1'b0;
    assign w_err_code = ERR_NONE;
`endif

    assign bus.cycle_idx     = r_cycle_idx;
    assign bus.sel_pc        = r_sel_pc;
    assign bus.mem_rd        = r_mem_rd;
    assign bus.ld_inst       = r_ld_inst;
    assign bus.ld_inc        = r_ld_inc;
    assign bus.sel_inc_ld_pc = r_sel_inc_ld_pc;
    assign bus.instr_done    = r_done;
    assign bus.instr_count   = r_count;
    assign bus.seq_err       = w_seq_err;
    assign bus.err_code      = w_err_code;

endmodule

// File: tb/tb_seq_state_decoder.sv
// Directed bench for seq_state_decoder. Each driven cycle pushes its
// expected registered response into a queue; a monitor pops and compares
// one entry just after every rising edge.
module tb_seq_state_decoder;
    import relay_seq_pkg::*;

    localparam int CNT_W = 16;
`ifdef SEQ_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_state_decoder_if #(.NUM_STATES(24), .CNT_W(CNT_W)) bus ();

    seq_state_decoder #(.NUM_STATES(24), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]       idx;
        logic [4:0]       strobes;   // sel_pc, mem_rd, ld_inst, ld_inc, sel_inc_ld_pc
        logic             done;
        logic [CNT_W-1:0] count;
        logic             err;
        logic [1:0]       code;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [CNT_W-1:0] m_count = '0;
    logic             m_err   = 1'b0;
    logic [1:0]       m_code  = 2'd0;

    function automatic logic [4:0] strobes_for(input logic [4:0] idx);
        logic [4:0] s;
        s[4] = (idx >= 5'd1) && (idx <= 5'd6);
        s[3] = (idx >= 5'd2) && (idx <= 5'd5);
        s[2] = (idx >= 5'd3) && (idx <= 5'd4);
        s[1] = (idx >= 5'd2) && (idx <= 5'd5);
        s[0] = (idx >= 5'd7) && (idx <= 5'd8);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One cycle of stimulus: st = 1..24 drives that state hot, 0 drives idle.
    task automatic step(input logic rst, input int st, input logic [3:0] bits, input logic done);
        logic [23:0] v;
        exp_t e;
        v = '0;
        if (st > 0) v[st-1] = 1'b1;
        reset = rst;
        bus.state_i = v;
        bus.instruction_bits = bits;
        if (rst) begin
            m_count = '0;
            m_err   = 1'b0;
            m_code  = 2'd0;
        end else if (done) begin
            m_count = m_count + 1'b1;
        end
        e.idx     = rst ? 5'd0 : 5'(st);
        e.strobes = strobes_for(e.idx);
        e.done    = rst ? 1'b0 : done;
        e.count   = m_count;
        e.err     = m_err;
        e.code    = m_code;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    // Walk states lo..hi of one class; done expected only at done_at.
    task automatic walk(input logic [3:0] bits, input int lo, input int hi, input int done_at);
        for (int s = lo; s <= hi; s++) begin
            step(1'b0, s, bits, s == done_at);
        end
    endtask

    // Expect the checker to flag this cause on the next driven cycle.
    task automatic expect_err(input logic [1:0] c);
        if (!m_err && CHK_EN) begin
            m_err  = 1'b1;
            m_code = c;
        end
    endtask

    // Monitor: every output sample corresponds to the oldest queued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle_idx",     32'(bus.cycle_idx),     32'(e.idx));
                chk("sel_pc",        32'(bus.sel_pc),        32'(e.strobes[4]));
                chk("mem_rd",        32'(bus.mem_rd),        32'(e.strobes[3]));
                chk("ld_inst",       32'(bus.ld_inst),       32'(e.strobes[2]));
                chk("ld_inc",        32'(bus.ld_inc),        32'(e.strobes[1]));
                chk("sel_inc_ld_pc", 32'(bus.sel_inc_ld_pc), 32'(e.strobes[0]));
                chk("instr_done",    32'(bus.instr_done),    32'(e.done));
                chk("instr_count",   32'(bus.instr_count),   32'(e.count));
                chk("seq_err",       32'(bus.seq_err),       32'(e.err));
                chk("err_code",      32'(bus.err_code),      32'(e.code));
                $display("cyc idx=%0d done=%0d cnt=%0d err=%0d code=%0d",
                         bus.cycle_idx, bus.instr_done, bus.instr_count, bus.seq_err, bus.err_code);
            end
        end
    end

    initial begin
        bus.state_i = '0;
        bus.instruction_bits = 4'd0;
        @(negedge clock);

        // 1: reset, partial alu instruction, then 2-cycle reset at state_5
        step(1'b1, 0, CLS_ALU, 1'b0);
        walk(CLS_ALU, 1, 5, 0);
        step(1'b1, 5, CLS_ALU, 1'b0);
        step(1'b1, 5, CLS_ALU, 1'b0);

        // 2: alu 1..8 then state_1
        walk(CLS_ALU, 1, 8, 8);
        step(1'b0, 1, CLS_GOTO, 1'b0);

        // 3: goto walk continues to 24, then back to 1
        walk(CLS_GOTO, 2, 24, 24);
        step(1'b0, 1, CLS_GOTO, 1'b0);

        // 4: idle while tracking -> not-one-hot, sticky through legal cycles
        step(1'b0, 2, CLS_GOTO, 1'b0);
        expect_err(ERR_ONEHOT);
        step(1'b0, 0, CLS_GOTO, 1'b0);
        walk(CLS_GOTO, 1, 3, 0);
        step(1'b1, 0, CLS_GOTO, 1'b0);

        // 5: inc_xy jumps 8 -> 1 (bad successor), then a legal 1..14 run
        walk(CLS_INCXY, 1, 8, 0);
        expect_err(ERR_SUCC);
        step(1'b0, 1, CLS_INCXY, 1'b0);
        walk(CLS_INCXY, 1, 14, 14);
        step(1'b0, 1, CLS_INCXY, 1'b0);
        step(1'b1, 0, CLS_INCXY, 1'b0);

        // 6: load_store latched, class bits change at state_12
        walk(CLS_LDST, 1, 11, 0);
        expect_err(ERR_CLASS);
        step(1'b0, 12, CLS_GOTO, 1'b1);
        step(1'b0, 1, CLS_LDST, 1'b0);
        step(1'b1, 0, CLS_LDST, 1'b0);

        // 7: counter preloaded to max, one instruction wraps it to 0
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        m_count = 16'hFFFF;
        step(1'b0, 0, CLS_ALU, 1'b0);
        walk(CLS_ALU, 1, 8, 8);
        step(1'b0, 0, CLS_ALU, 1'b0);

        // drain the scoreboard, bounded
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
